// File: rtl/kick_sequencer_pkg.sv
// Shared types and default timing constants for the kicker sequencer.
package kicker_pkg;

   localparam int POWER_W = 8;

   localparam int unsigned DEF_FIRE_UNIT      = 32'd4096;
   localparam int unsigned DEF_COOLDOWN_CYC   = 32'd1000000;
   localparam int unsigned DEF_ARM_TIMEOUT    = 32'd25000000;
   localparam int unsigned DEF_CHARGE_TIMEOUT = 32'd100000000;

   typedef enum logic [2:0] {
      ST_CHARGE = 3'd0,
      ST_READY  = 3'd1,
      ST_ARMED  = 3'd2,
      ST_FIRE   = 3'd3,
      ST_COOL   = 3'd4,
      ST_FAULT  = 3'd5
   } kick_state_e;

   function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/kick_sequencer_if.sv
// Request/grant, sensor and charger/solenoid signals of the kick sequencer.
interface kick_sequencer_if;
   import kicker_pkg::*;

   logic               done;
   logic               ir;
   logic               req_host;
   logic [POWER_W-1:0] host_power;
   logic               req_auto;
   logic [POWER_W-1:0] auto_power;
   logic               fault_clr;
   logic               ack_host;
   logic               ack_auto;
   logic               fired;
   logic               charge;
   logic               trigger;
   logic               ready;
   logic               fault;
   logic [2:0]         state;

   modport master (
      output done, ir, req_host, host_power, req_auto, auto_power, fault_clr,
      input  ack_host, ack_auto, fired, charge, trigger, ready, fault, state
   );

   modport slave (
      input  done, ir, req_host, host_power, req_auto, auto_power, fault_clr,
      output ack_host, ack_auto, fired, charge, trigger, ready, fault, state
   );

endinterface

// File: rtl/kick_sequencer_timer.sv
// Loadable down-counter with terminal-count flag; holds at zero.
module kick_timer #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         i_load,
   input  logic         i_en,
   input  logic [W-1:0] i_value,
   output logic         o_zero
);

   logic [W-1:0] r_count;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_count <= '0;
      end else if (i_load) begin
         r_count <= i_value;
      end else if (i_en && (r_count != '0)) begin
         r_count <= r_count - W'(1);
      end
   end

   assign o_zero = (r_count == '0);

endmodule

// File: rtl/kick_sequencer.sv
// Kick sequencer: arbitrates host/auto kick requests and sequences charge, fire and cooldown.
//
// state  | meaning
// CHARGE | charger on, waiting for done; timeout -> FAULT
// READY  | charger topping up, arbitrating requests (host over auto)
// ARMED  | charger off, waiting for ir; timeout -> READY
// FIRE   | solenoid driven for power x FIRE_UNIT cycles
// COOL   | charger and solenoid off for COOLDOWN_CYC cycles
// FAULT  | everything off until fault_clr
module kick_sequencer
   import kicker_pkg::*;
#(
   parameter int unsigned FIRE_UNIT      = DEF_FIRE_UNIT,
   parameter int unsigned COOLDOWN_CYC   = DEF_COOLDOWN_CYC,
   parameter int unsigned ARM_TIMEOUT    = DEF_ARM_TIMEOUT,
   parameter int unsigned CHARGE_TIMEOUT = DEF_CHARGE_TIMEOUT
) (
   input  logic            clk,
   input  logic            rst_n,
   kick_sequencer_if.slave bus
);

   localparam int          PROD_W         = POWER_W + $clog2(FIRE_UNIT);
   localparam int unsigned MAX_FIRE_LOAD  = ((32'd1 << POWER_W) - 32'd1) * FIRE_UNIT;
   localparam int unsigned MAX_LOAD       = max_u(max_u(CHARGE_TIMEOUT, ARM_TIMEOUT),
                                                  max_u(COOLDOWN_CYC, MAX_FIRE_LOAD));
   localparam int          TW             = $clog2(MAX_LOAD + 32'd1);

   kick_state_e        r_state;
   kick_state_e        w_next;
   logic               r_first;
   logic [POWER_W-1:0] r_power;
   logic               r_ack_host;
   logic               r_ack_auto;
   logic               r_fired;
   logic               r_charge;
   logic               r_trigger;
   logic               r_ready;
   logic               r_fault;

   logic [PROD_W-1:0]  w_fire_prod;
   logic               w_tmr_load;
   logic               w_tmr_en;
   logic [TW-1:0]      w_tmr_val;
   logic               w_tmr_zero;

   assign w_fire_prod = PROD_W'(r_power) * PROD_W'(FIRE_UNIT);

   kick_timer #(.W(TW)) u_timer (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_load  (w_tmr_load),
      .i_en    (w_tmr_en),
      .i_value (w_tmr_val),
      .o_zero  (w_tmr_zero)
   );

   always_comb begin
      w_next = r_state;
      case (r_state)
         ST_CHARGE: begin
            // The timer comes out of reset at zero, so the first cycle only loads it.
            if (bus.done)                      w_next = ST_READY;
            else if (w_tmr_zero && !r_first)   w_next = ST_FAULT;
         end
         ST_READY: begin
            if (bus.req_host || bus.req_auto)  w_next = ST_ARMED;
            else if (!bus.done)                w_next = ST_CHARGE;
         end
         ST_ARMED: begin
            if (r_power == '0)                 w_next = ST_COOL;
            else if (bus.ir)                   w_next = ST_FIRE;
            else if (w_tmr_zero)               w_next = ST_READY;
         end
         ST_FIRE:  if (w_tmr_zero)             w_next = ST_COOL;
         ST_COOL:  if (w_tmr_zero)             w_next = ST_CHARGE;
         ST_FAULT: if (bus.fault_clr)          w_next = ST_CHARGE;
         default:                              w_next = ST_CHARGE;
      endcase

      // Loads are N-1 so the state lasts exactly N cycles up to the zero compare.
      w_tmr_load = r_first || (w_next != r_state);
      w_tmr_en   = (r_state != ST_READY) && (r_state != ST_FAULT);
      w_tmr_val  = '0;
      case (w_next)
         ST_CHARGE: w_tmr_val = TW'(CHARGE_TIMEOUT - 32'd1);
         ST_ARMED:  w_tmr_val = TW'(ARM_TIMEOUT - 32'd1);
         ST_FIRE:   w_tmr_val = TW'(w_fire_prod) - TW'(1);
         ST_COOL:   w_tmr_val = TW'(COOLDOWN_CYC - 32'd1);
         default:   w_tmr_val = '0;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= ST_CHARGE;
         r_first    <= 1'b1;
         r_power    <= '0;
         r_ack_host <= 1'b0;
         r_ack_auto <= 1'b0;
         r_fired    <= 1'b0;
         r_charge   <= 1'b0;
         r_trigger  <= 1'b0;
         r_ready    <= 1'b0;
         r_fault    <= 1'b0;
      end else begin
         r_state <= w_next;
         r_first <= 1'b0;
         if (r_state == ST_READY) begin
            if (bus.req_host)      r_power <= bus.host_power;
            else if (bus.req_auto) r_power <= bus.auto_power;
         end
         r_ack_host <= (r_state == ST_READY) && bus.req_host;
         r_ack_auto <= (r_state == ST_READY) && !bus.req_host && bus.req_auto;
         r_charge   <= (r_state == ST_CHARGE) || (r_state == ST_READY);
         r_trigger  <= (r_state == ST_FIRE);
         r_fired    <= (r_state == ST_FIRE) && w_tmr_zero;
         r_ready    <= (r_state == ST_READY);
         r_fault    <= (r_state == ST_FAULT);
      end
   end

   assign bus.ack_host = r_ack_host;
   assign bus.ack_auto = r_ack_auto;
   assign bus.fired    = r_fired;
   assign bus.charge   = r_charge;
   assign bus.trigger  = r_trigger;
   assign bus.ready    = r_ready;
   assign bus.fault    = r_fault;
   assign bus.state    = r_state;

endmodule

// File: tb/tb_kick_sequencer.sv
// Directed plus randomized bench for kick_sequencer with a transaction-level expectation model.
module tb_kick_sequencer;

   localparam int FU = 4;
   localparam int CD = 16;
   localparam int AT = 50;
   localparam int CT = 100;

   localparam logic [2:0] S_CHARGE = 3'd0;
   localparam logic [2:0] S_READY  = 3'd1;
   localparam logic [2:0] S_ARMED  = 3'd2;
   localparam logic [2:0] S_COOL   = 3'd4;
   localparam logic [2:0] S_FAULT  = 3'd5;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   kick_sequencer_if bus();

   kick_sequencer #(
      .FIRE_UNIT      (FU),
      .COOLDOWN_CYC   (CD),
      .ARM_TIMEOUT    (AT),
      .CHARGE_TIMEOUT (CT)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int exp_host = 0;
   int exp_auto = 0;

   // observed activity, gathered at every falling edge
   int trig_rises = 0, fired_cnt = 0, fired_stray = 0, fired_early = 0, overlap = 0;
   int host_acks = 0, auto_acks = 0, trig_len = 0, last_width = -1, cool_len = 0, widths_seen = 0;
   bit cool_cnt = 0, last_fired_ok = 0, prev_trig = 0, prev_fired = 0;

   always @(negedge clk) begin
      if (!rst_n) begin
         trig_len   <= 0;
         prev_trig  <= 1'b0;
         prev_fired <= 1'b0;
         cool_cnt   <= 1'b0;
      end else begin
         if (bus.charge && bus.trigger) overlap <= overlap + 1;
         if (bus.ack_host) host_acks <= host_acks + 1;
         if (bus.ack_auto) auto_acks <= auto_acks + 1;
         if (bus.fired) fired_cnt <= fired_cnt + 1;
         if (bus.fired && !bus.trigger) fired_stray <= fired_stray + 1;
         if (prev_fired && bus.trigger) fired_early <= fired_early + 1;
         if (bus.trigger) trig_len <= prev_trig ? trig_len + 1 : 1;
         if (bus.trigger && !prev_trig) trig_rises <= trig_rises + 1;
         if (!bus.trigger && prev_trig) begin
            last_width    <= trig_len;
            last_fired_ok <= prev_fired;
            widths_seen   <= widths_seen + 1;
            cool_cnt      <= 1'b1;
            cool_len      <= bus.charge ? 0 : 1;
         end else if (cool_cnt) begin
            if (!bus.charge) cool_len <= cool_len + 1;
            else             cool_cnt <= 1'b0;
         end
         prev_trig  <= bus.trigger;
         prev_fired <= bus.fired;
      end
   end

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic wait_state(input logic [2:0] s, input int budget, input string tag);
      int n = 0;
      while (bus.state !== s && n < budget) begin
         tick();
         n++;
      end
      check(tag, 32'(bus.state), 32'(s));
   endtask

   task automatic apply_reset(input bit d);
      rst_n          = 1'b0;
      bus.done       = d;
      bus.ir         = 1'b0;
      bus.req_host   = 1'b0;
      bus.req_auto   = 1'b0;
      bus.host_power = '0;
      bus.auto_power = '0;
      bus.fault_clr  = 1'b0;
      repeat (2) tick();
      check("rst_state",   32'(bus.state),    32'(S_CHARGE));
      check("rst_charge",  32'(bus.charge),   32'd0);
      check("rst_trigger", 32'(bus.trigger),  32'd0);
      check("rst_fault",   32'(bus.fault),    32'd0);
      check("rst_ack",     32'({bus.ack_host, bus.ack_auto, bus.fired}), 32'd0);
   endtask

   // One request/fire/cooldown transaction; the loser of a double request keeps holding.
   task automatic do_kick(input bit rh, input bit ra, input int ph, input int pa, input int ir_dly);
      int wp, n, r0, f0;
      wait_state(S_READY, 300, "wait_ready");
      wp             = rh ? ph : pa;
      bus.req_host   = rh;
      bus.host_power = ph[7:0];
      bus.req_auto   = ra;
      bus.auto_power = pa[7:0];
      r0 = trig_rises;
      f0 = fired_cnt;
      tick();
      check("ack_host", 32'(bus.ack_host), 32'(rh));
      check("ack_auto", 32'(bus.ack_auto), 32'(!rh && ra));
      check("armed",    32'(bus.state),    32'(S_ARMED));
      if (rh) begin exp_host++; bus.req_host = 1'b0; end
      else    begin exp_auto++; bus.req_auto = 1'b0; end
      if (wp == 0) begin
         bus.ir = 1'b1;
         tick();
         check("zero_pwr_cool", 32'(bus.state), 32'(S_COOL));
         wait_state(S_READY, 60, "zero_pwr_back");
         bus.ir = 1'b0;
         check("zero_pwr_no_trig",  32'(trig_rises), 32'(r0));
         check("zero_pwr_no_fired", 32'(fired_cnt),  32'(f0));
      end else begin
         repeat (ir_dly) tick();
         bus.ir = 1'b1;
         n = 0;
         while (bus.trigger !== 1'b1 && n < 10) begin tick(); n++; end
         check("ir_to_trigger", 32'(n), 32'd2);
         n = 0;
         while (bus.trigger !== 1'b0 && n < wp * FU + 10) begin tick(); n++; end
         check("trigger_fell", 32'(bus.trigger), 32'd0);
         bus.ir = 1'b0;
         n = 0;
         while (bus.charge !== 1'b1 && n < CD + 10) begin tick(); n++; end
         check("charge_back", 32'(bus.charge),   32'd1);
         check("width",       32'(last_width),   32'(wp * FU));
         check("fired_last",  32'(last_fired_ok), 32'd1);
         check("fired_once",  32'(fired_cnt),    32'(f0 + 1));
         check("cooldown",    32'(cool_len >= CD), 32'd1);
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      int n, f0, w0, mode, ph, pa, d;

      apply_reset(1'b0);
      rst_n = 1'b1;
      tick();
      check("charge_cycle1", 32'(bus.charge), 32'd1);
      check("state_charge",  32'(bus.state),  32'(S_CHARGE));
      repeat (3) tick();
      bus.done = 1'b1;
      wait_state(S_READY, 10, "first_ready");
      tick();
      check("ready_out",    32'(bus.ready),   32'd1);
      check("no_trig_init", 32'(trig_rises),  32'd0);

      do_kick(1'b1, 1'b0, 3, 0, 0);

      do_kick(1'b1, 1'b1, int'($urandom_range(1, 8)), 7, 2);
      do_kick(1'b0, 1'b1, 0, 7, 1);

      for (int i = 0; i < 6; i++) begin
         mode = int'($urandom_range(0, 2));
         ph   = int'($urandom_range(1, 15));
         pa   = int'($urandom_range(1, 15));
         d    = int'($urandom_range(0, 10));
         if (mode == 0)      do_kick(1'b1, 1'b0, ph, pa, d);
         else if (mode == 1) do_kick(1'b0, 1'b1, ph, pa, d);
         else begin
            do_kick(1'b1, 1'b1, ph, pa, d);
            do_kick(1'b0, 1'b1, ph, pa, int'($urandom_range(0, 10)));
         end
      end

      // armed with no ball: back to READY after the arm timeout
      wait_state(S_READY, 300, "arm_ready");
      bus.req_host   = 1'b1;
      bus.host_power = 8'd5;
      tick();
      check("arm_ack", 32'(bus.ack_host), 32'd1);
      exp_host++;
      bus.req_host = 1'b0;
      f0 = trig_rises;
      n  = 0;
      while (bus.state !== S_READY && n < AT + 10) begin tick(); n++; end
      check("arm_timeout_cycles", 32'(n), 32'(AT));
      check("arm_no_trigger",     32'(trig_rises), 32'(f0));

      do_kick(1'b1, 1'b0, 0, 0, 0);

      // charger never reports done
      apply_reset(1'b0);
      rst_n = 1'b1;
      n = 0;
      while (bus.fault !== 1'b1 && n < CT + 20) begin tick(); n++; end
      check("fault_window", 32'(n >= CT && n <= CT + 3), 32'd1);
      check("fault_charge", 32'(bus.charge), 32'd0);
      check("fault_state",  32'(bus.state),  32'(S_FAULT));
      bus.done = 1'b1;
      repeat (5) tick();
      check("fault_sticky", 32'(bus.state), 32'(S_FAULT));
      bus.fault_clr = 1'b1;
      tick();
      bus.fault_clr = 1'b0;
      check("clr_to_charge", 32'(bus.state), 32'(S_CHARGE));
      tick();
      check("clr_charge", 32'(bus.charge), 32'd1);
      check("clr_fault",  32'(bus.fault),  32'd0);

      // reset in the middle of a full-power fire
      wait_state(S_READY, 20, "rf_ready");
      bus.req_host   = 1'b1;
      bus.host_power = 8'd255;
      tick();
      check("rf_ack", 32'(bus.ack_host), 32'd1);
      exp_host++;
      bus.req_host = 1'b0;
      bus.ir       = 1'b1;
      n = 0;
      while (bus.trigger !== 1'b1 && n < 10) begin tick(); n++; end
      check("rf_trigger_on", 32'(bus.trigger), 32'd1);
      repeat ($urandom_range(50, 500)) tick();
      f0 = fired_cnt;
      w0 = widths_seen;
      rst_n = 1'b0;
      #1;
      check("rf_trigger_off", 32'(bus.trigger), 32'd0);
      check("rf_state",       32'(bus.state),   32'(S_CHARGE));
      tick();
      rst_n  = 1'b1;
      bus.ir = 1'b0;
      tick();
      check("rf_no_fired", 32'(fired_cnt),   32'(f0));
      check("rf_no_width", 32'(widths_seen), 32'(w0));

      do_kick(1'b0, 1'b1, 0, int'($urandom_range(1, 6)), 0);

      check("host_ack_total", 32'(host_acks),   32'(exp_host));
      check("auto_ack_total", 32'(auto_acks),   32'(exp_auto));
      check("charge_trig_ovl", 32'(overlap),    32'd0);
      check("fired_stray",    32'(fired_stray), 32'd0);
      check("fired_early",    32'(fired_early), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/kick_sequencer.md
# kick_sequencer

Controller in front of the kicker's charger/solenoid path. Arbitrates kick requests from the host command path and the on-board auto-kick logic. Sequences capacitor charging, IR-gated firing with a programmed pulse width, and a post-kick cooldown. Drives the charger enable and the solenoid trigger directly; charge and trigger are never asserted together.

## Interface
Parameters:
- FIRE_UNIT, 4096: clk cycles per LSB of kick power.
- COOLDOWN_CYC, 1000000: cycles charge is held off after a fire.
- ARM_TIMEOUT, 25000000: cycles to wait for ir once armed.
- CHARGE_TIMEOUT, 100000000: max cycles in CHARGE before fault.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- done  in  1  charger reports capacitor full (level).
- ir  in  1  ball-present sensor (level, synchronised upstream).
- req_host  in  1  host kick request (level, held until ack).
- host_power  in  8  host kick power; sampled on ack_host.
- req_auto  in  1  auto-kick request (level, held until ack).
- auto_power  in  8  auto kick power; sampled on ack_auto.
- fault_clr  in  1  one-cycle pulse; clears FAULT.
- ack_host, ack_auto  out  1  one-cycle grant pulses.
- fired  out  1  one-cycle pulse on the last trigger cycle.
- charge  out  1  charger enable, registered.
- trigger  out  1  solenoid drive, registered.
- ready  out  1  high in READY.
- fault  out  1  high in FAULT.
- state  out  3  current state encoding, for debug.

## Operation
- States: CHARGE=0, READY=1, ARMED=2, FIRE=3, COOL=4, FAULT=5.
- Reset: state CHARGE, all timers 0. Outputs charge, trigger, ack_*, fired and fault are 0. state=0.
- CHARGE: charge=1. done → READY. Timer reaching CHARGE_TIMEOUT with no done → FAULT.
- READY: charge=1 (top-up). Requests are arbitrated here:
  - req_host wins over req_auto.
  - Grant pulses ack_x for one cycle, latches power into an 8-bit register and goes to ARMED.
  - If done drops, go back to CHARGE with no grant.
- ARMED: charge=0.
  - ir=1 → FIRE, trigger timer loaded with power×FIRE_UNIT.
  - Latched power=0 → COOL directly, with no trigger and no fired pulse.
  - Timer reaching ARM_TIMEOUT → READY, no fire.
- FIRE: trigger=1 for exactly power×FIRE_UNIT cycles, then → COOL. fired pulses on the final trigger cycle.
- COOL: charge=0, trigger=0 for COOLDOWN_CYC cycles, then → CHARGE.
- FAULT: charge=0, trigger=0, fault=1. Only fault_clr leaves FAULT, and it goes to CHARGE.
- Requests outside READY are not acked; requesters keep holding.
- Power product width: 8 bits + clog2(FIRE_UNIT). The timer is a single down-counter, sized for the maximum of all loads, with no overflow.
- A request dropped before it is granted is simply not acked.
- Same-cycle events:
  - done falling in the same cycle as a grant: the grant wins.
  - ir rising on the same cycle as ARM_TIMEOUT expiry: fire wins.
- Asynchronous reset mid-FIRE drops trigger immediately.

## Timing
- Registered outputs update one cycle after the causing state transition.
- Request to ack: 1 cycle when in READY.
- ir rising in ARMED to trigger high: 2 cycles (sample, then register).
- trigger high width is exactly power×FIRE_UNIT cycles.
- charge goes low one cycle before trigger can go high (ARMED), and stays low until COOL ends.
- fired coincides with the last trigger=1 cycle.

## Structure
- Package kicker_pkg holds:
  - the state enum (3-bit, values above);
  - the power width constant (8);
  - default timing constants.
- One sub-module, kick_timer: loadable down-counter with load, en, zero flag and parameterised width. It is shared across CHARGE, ARMED, FIRE and COOL timeouts; each state entry reloads it.
- The FSM and arbiter stay in kick_sequencer.

## Test plan
Bench parameters: FIRE_UNIT=4, COOLDOWN_CYC=16, ARM_TIMEOUT=50, CHARGE_TIMEOUT=100.
- Reset, then done=1 at cycle 5 → charge=1 from cycle 1, ready=1 after done; trigger stays 0.
- READY, req_host=1 with power 3, ir=1 → one ack_host, trigger high exactly 12 cycles, fired on the 12th, charge=0 for ≥16 cycles after.
- req_host and req_auto both high in READY → ack_host only; after cooldown and recharge, held req_auto → ack_auto.
- Armed with power 5, ir=0 for 50 cycles → back to READY, trigger never high. Separately, power=0 with ir=1 → COOL, no fired pulse.
- done never asserted → fault=1 at cycle ~100, charge=0. fault_clr → CHARGE with charge=1.
- rst_n low for 1 cycle midway through a power-255 fire → trigger=0 immediately, state=0, no fired pulse.
